// File: rtl/gray_mem_arbiter.sv
// Round-robin arbiter sharing the gray-image read port between two requesters,
// with burst locking and a fixed two-cycle tagged read-data return path.
module gray_mem_arbiter #(
  parameter int unsigned AW        = 14,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] CNT_SAT = BW'(MAX_BURST - 1);

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic          ready_seen_q;
  logic          last_owner_q, last_owner_d;
  logic          owned_q, owned_d;
  logic          lock_q, lock_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  tag_t          stage1_q, stage1_d;
  tag_t          stage2_q;
  logic          gray_req_q;
  logic [AW-1:0] gray_addr_q, gray_addr_d;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          gnt_vld, gnt_id, keep_owner;

  // Arbitration: the locked previous owner keeps the port until its burst limit.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    keep_owner = owned_q && lock_q && (burst_cnt_q < CNT_SAT);
    if (ready_seen_q) begin
      if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_id  = keep_owner ? last_owner_q : ~last_owner_q;
      end else if (req0 || req1) begin
        gnt_vld = 1'b1;
        gnt_id  = req1;
      end
    end
  end

  assign gnt0 = gnt_vld & ~gnt_id;
  assign gnt1 = gnt_vld & gnt_id;

  // Issue side next state: owner history, burst count and the outgoing tag.
  always_comb begin
    last_owner_d = last_owner_q;
    owned_d      = gnt_vld;
    lock_d       = 1'b0;
    burst_cnt_d  = '0;
    gray_addr_d  = gray_addr_q;
    stage1_d.vld = gnt_vld;
    stage1_d.id  = gnt_id;
    if (gnt_vld) begin
      last_owner_d = gnt_id;
      lock_d       = gnt_id ? lock1 : lock0;
      gray_addr_d  = gnt_id ? addr1 : addr0;
      if (owned_q && (gnt_id == last_owner_q)) begin
        burst_cnt_d = (burst_cnt_q == CNT_SAT) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_seen_q <= 1'b0;
      last_owner_q <= 1'b1;
      owned_q      <= 1'b0;
      lock_q       <= 1'b0;
      burst_cnt_q  <= '0;
      stage1_q     <= '0;
      stage2_q     <= '0;
      gray_req_q   <= 1'b0;
      gray_addr_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ready_seen_q <= ready_seen_q | gray_ready;
      last_owner_q <= last_owner_d;
      owned_q      <= owned_d;
      lock_q       <= lock_d;
      burst_cnt_q  <= burst_cnt_d;
      stage1_q     <= stage1_d;
      stage2_q     <= stage1_q;
      gray_req_q   <= gnt_vld;
      gray_addr_q  <= gray_addr_d;
      // Memory data belongs to the request tagged one stage earlier.
      if (stage1_q.vld && !stage1_q.id) begin
        rdata0_q <= gray_data;
      end
      if (stage1_q.vld && stage1_q.id) begin
        rdata1_q <= gray_data;
      end
    end
  end

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign rvalid0   = stage2_q.vld & ~stage2_q.id;
  assign rvalid1   = stage2_q.vld & stage2_q.id;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = stage1_q.vld | stage2_q.vld | gray_req_q;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Bench for gray_mem_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_gray_mem_arbiter;

  localparam int unsigned AW        = 14;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 9;

  logic          clk;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          lock0, lock1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  gray_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy)
  );

  assign gray_data = mem[gray_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model state
  typedef struct {
    int            cyc;
    int            id;
    logic [AW-1:0] addr;
  } ent_t;

  int            m_ready    = 0;
  int            m_last     = 1;
  int            m_run      = 0;
  int            m_lockprev = 0;
  int            m_greq     = 0;
  int            m_gprev    = -1;
  logic [AW-1:0] m_gaddr    = '0;
  logic [DW-1:0] m_rdata [2];
  ent_t          pend[$];
  int            ccount     = 0;

  int            tr_id[$];
  int            tr_cyc[$];
  logic [DW-1:0] rd0[$];
  int            rv1_cnt    = 0;

  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];

  always @(negedge clk) begin : checker_blk
    int            eg;
    logic          ev0, ev1, ebusy;
    logic [AW-1:0] ga;
    if (rvalid1) rv1_cnt++;
    if (reset) begin
      m_ready = 0; m_last = 1; m_run = 0; m_lockprev = 0; m_greq = 0;
      m_gprev = -1; m_gaddr = '0; m_rdata[0] = '0; m_rdata[1] = '0;
      pend.delete();
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_gray_req", 32'(gray_req), 0);
      chk("rst_gray_addr", 32'(gray_addr), 0);
      chk("rst_rvalid0", 32'(rvalid0), 0);
      chk("rst_rvalid1", 32'(rvalid1), 0);
      chk("rst_rdata0", 32'(rdata0), 0);
      chk("rst_rdata1", 32'(rdata1), 0);
      chk("rst_busy", 32'(busy), 0);
    end else begin
      eg = -1;
      if (m_ready != 0) begin
        if (req0 && req1)
          eg = (m_lockprev != 0 && m_run > 0 && m_run < int'(MAX_BURST)) ? m_last : 1 - m_last;
        else if (req0) eg = 0;
        else if (req1) eg = 1;
      end
      ev0 = 1'b0; ev1 = 1'b0; ebusy = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].cyc == ccount - 2) begin
          if (pend[i].id == 0) ev0 = 1'b1; else ev1 = 1'b1;
          m_rdata[pend[i].id] = mem[pend[i].addr];
        end
        if (pend[i].cyc >= ccount - 2) ebusy = 1'b1;
      end
      chk("gnt0", 32'(gnt0), 32'(eg == 0));
      chk("gnt1", 32'(gnt1), 32'(eg == 1));
      chk("gray_req", 32'(gray_req), 32'(m_greq));
      chk("gray_addr", 32'(gray_addr), 32'(m_gaddr));
      chk("rvalid0", 32'(rvalid0), 32'(ev0));
      chk("rvalid1", 32'(rvalid1), 32'(ev1));
      chk("rdata0", 32'(rdata0), 32'(m_rdata[0]));
      chk("rdata1", 32'(rdata1), 32'(m_rdata[1]));
      chk("busy", 32'(busy), 32'(ebusy));
      if (gnt0 || gnt1) begin
        tr_id.push_back((gnt0 && gnt1) ? 2 : (gnt0 ? 0 : 1));
        tr_cyc.push_back(ccount);
      end
      if (rvalid0) rd0.push_back(rdata0);
      // Advance the model by one cycle
      if (eg >= 0) begin
        ga = (eg == 0) ? addr0 : addr1;
        m_run = (eg == m_last && m_run > 0) ? m_run + 1 : 1;
        m_last = eg;
        m_lockprev = (eg == 0) ? int'(lock0) : int'(lock1);
        pend.push_back('{cyc: ccount, id: eg, addr: ga});
        m_gaddr = ga;
        m_greq = 1;
      end else begin
        m_run = 0;
        m_lockprev = 0;
        m_greq = 0;
      end
      m_gprev = eg;
      while (pend.size() > 0 && pend[0].cyc <= ccount - 2) void'(pend.pop_front());
      if (gray_ready) m_ready = 1;
    end
    ccount++;
  end

  task automatic present();
    req0 = (q0.size() != 0);
    if (q0.size() != 0) addr0 = q0[0];
    req1 = (q1.size() != 0);
    if (q1.size() != 0) addr1 = q1[0];
  endtask

  // Advance to just after the next edge; granted requests retire from their queues.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (m_gprev == 0 && q0.size() != 0) void'(q0.pop_front());
    if (m_gprev == 1 && q1.size() != 0) void'(q1.pop_front());
    present();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    tr_id.delete(); tr_cyc.delete(); rd0.delete();
  endtask

  task automatic wait_grants(input int n, input int lim, input string name);
    int k = 0;
    while (tr_id.size() < n && k < lim) begin
      cycle();
      k++;
    end
    chk(name, 32'(tr_id.size() >= n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] win [9];
    int            k;
    int            zeros;
    win[0] = 14'h0000; win[1] = 14'h0001; win[2] = 14'h0002;
    win[3] = 14'h0080; win[4] = 14'h0081; win[5] = 14'h0082;
    win[6] = 14'h0100; win[7] = 14'h0101; win[8] = 14'h0102;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    reset = 1'b1; gray_ready = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; lock0 = 1'b0; lock1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // No grants before the memory reports ready
    q0.push_back(14'h0081);
    present();
    repeat (5) begin
      #1 chk("t1_gnt0_not_ready", 32'(gnt0), 0);
      cycle();
    end
    gray_ready = 1'b1;
    #1 chk("t1_gnt0_ready_rise", 32'(gnt0), 0);
    cycle();
    #1 chk("t1_gnt0", 32'(gnt0), 1);
    cycle();
    #1 chk("t1_gray_req", 32'(gray_req), 1);
    chk("t1_gray_addr", 32'(gray_addr), 32'h0081);
    cycle();
    #1 chk("t1_rvalid0", 32'(rvalid0), 1);
    chk("t1_rdata0", 32'(rdata0), 32'(mem[14'h0081]));
    cycle();

    // Round-robin alternation with both requesters saturated
    do_reset();
    repeat (4) begin
      q0.push_back(AW'($urandom));
      q1.push_back(AW'($urandom));
    end
    present();
    wait_grants(8, 30, "t2_wait");
    if (tr_id.size() >= 8)
      for (int i = 0; i < 8; i++) chk("t2_alternate", 32'(tr_id[i]), 32'(i % 2));
    repeat (4) cycle();

    // Locked streaming, then the burst limit while req1 pends
    do_reset();
    lock0 = 1'b1;
    repeat (30) q0.push_back(AW'($urandom));
    present();
    wait_grants(20, 40, "t3_wait_stream");
    zeros = 0;
    for (int i = 0; i < tr_id.size() && i < 20; i++) if (tr_id[i] == 0) zeros++;
    chk("t3_stream_gnt0", 32'(zeros), 20);
    if (tr_cyc.size() >= 20) chk("t3_no_bubbles", 32'(tr_cyc[19] - tr_cyc[0]), 19);
    q1.push_back(AW'($urandom));
    q1.push_back(AW'($urandom));
    present();
    wait_grants(31, 40, "t3_wait_limit");
    if (tr_id.size() >= 31) begin
      chk("t3_gnt1_after_sat", 32'(tr_id[20]), 1);
      zeros = 0;
      for (int i = 21; i < 30; i++) if (tr_id[i] == 0) zeros++;
      chk("t3_burst_of_9", 32'(zeros), 9);
      chk("t3_gnt1_after_burst", 32'(tr_id[30]), 1);
    end
    repeat (6) cycle();

    // 3x3 window fetched as one locked burst
    do_reset();
    lock0 = 1'b1;
    for (int i = 0; i < 9; i++) q0.push_back(win[i]);
    q1.push_back(14'h3fff);
    present();
    wait_grants(10, 30, "t4_wait");
    if (tr_id.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk("t4_grant_order", 32'(tr_id[i]), (i < 9) ? 32'd0 : 32'd1);
      chk("t4_uninterrupted", 32'(tr_cyc[8] - tr_cyc[0]), 8);
    end
    repeat (4) cycle();
    chk("t4_rd0_count", 32'(rd0.size()), 9);
    if (rd0.size() >= 9)
      for (int i = 0; i < 9; i++) chk("t4_rdata0_order", 32'(rd0[i]), 32'(mem[win[i]]));

    // Reset right after a grant discards the in-flight read
    do_reset();
    lock0 = 1'b0;
    q1.push_back(14'h1234);
    present();
    k = 0;
    while (m_gprev != 1 && k < 20) begin
      cycle();
      k++;
    end
    chk("t5_wait_gnt1", 32'(m_gprev == 1), 1);
    reset = 1'b1;
    rv1_cnt = 0;
    q0.delete(); q1.delete();
    req0 = 1'b0; req1 = 1'b0;
    #1 chk("t5_gray_req", 32'(gray_req), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rvalid1", 32'(rvalid1), 0);
    repeat (3) cycle();
    reset = 1'b0;
    gray_ready = 1'b0;
    q0.push_back(14'h0042);
    present();
    repeat (3) begin
      #1 chk("t5_ready_cleared", 32'(gnt0), 0);
      cycle();
    end
    chk("t5_no_rvalid1", 32'(rv1_cnt), 0);
    gray_ready = 1'b1;
    repeat (5) cycle();

    // req1 drops as its data returns while req0 takes the port
    do_reset();
    cycle();
    q1.push_back(14'h0aaa);
    q1.push_back(14'h0bbb);
    present();
    cycle();
    cycle();
    q0.push_back(14'h0ccc);
    present();
    #1 chk("t6_rvalid1", 32'(rvalid1), 1);
    chk("t6_rdata1", 32'(rdata1), 32'(mem[14'h0aaa]));
    chk("t6_gnt0", 32'(gnt0), 1);
    cycle();
    cycle();
    #1 chk("t6_busy_hold", 32'(busy), 1);
    cycle();
    #1 chk("t6_busy_fall", 32'(busy), 0);

    // Randomized traffic with occasional resets and late readiness
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        gray_ready = ($urandom_range(0, 3) != 0);
        if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(AW'($urandom));
        if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(AW'($urandom));
        if ($urandom_range(0, 7) == 0) lock0 = ~lock0;
        if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
        present();
        cycle();
      end
    end
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
